set_ctrl: RTL and testbench
===========================

SET_CTRL -- requirements
Module: set_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 15, maximum WAIT-state cycles before abort.
REQ-002 clk  in  1  single clock, all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 req_valid  in  1  set-instruction request present.
REQ-005 req_ready  out  1  controller can accept a request.
REQ-006 req_op  in  2  00 SEQ, 01 SLT, 10 SGE, 11 SCO.
REQ-007 req_rs, req_rt  in  16  source operands.
REQ-008 req_rd  in  3  destination register index.
REQ-009 alu_a, alu_b  out  16  ALU operands.
REQ-010 alu_sub  out  1  1 = A-B, 0 = A+B.
REQ-011 alu_start  out  1  one-cycle ALU launch pulse.
REQ-012 alu_done  in  1  ALU result and flags valid this cycle.
REQ-013 alu_zero, alu_cout, alu_msb  in  1 each  ALU flags, sampled only with alu_done.
REQ-014 wb_valid  out  1  write-back result present.
REQ-015 wb_ready  in  1  register file accepts write-back.
REQ-016 wb_data  out  16  {15'b0, set bit}.
REQ-017 wb_reg  out  3  destination index.
REQ-018 err  out  1  sticky ALU-timeout flag.

Function
REQ-019 FSM states IDLE, ISSUE, WAIT, WB; req_ready SHALL be 1 only in IDLE.
REQ-020 IDLE: req_valid=1 -> latch op/rs/rt/rd, go ISSUE; else stay.
REQ-021 ISSUE: alu_start=1 for exactly this cycle, go WAIT, timeout counter cleared to 0.
REQ-022 alu_a/alu_b SHALL drive latched rs/rt from ISSUE through WAIT; alu_sub=1 for SEQ/SLT/SGE, 0 for SCO.
REQ-023 WAIT: alu_done=1 -> capture set bit, go WB; alu_done is ignored in all other states.
REQ-024 Set bit: SEQ=zero, SLT=msb, SGE=~msb, SCO=cout.
REQ-025 WAIT without alu_done: counter increments; when counter == TIMEOUT-1 and alu_done=0 -> err=1, go IDLE, no write-back.
REQ-026 alu_done on the timeout cycle SHALL win: normal WB, err unchanged.
REQ-027 WB: wb_valid=1 with stable wb_data/wb_reg until wb_ready=1; on handshake go IDLE.
REQ-028 Latency: request accepted cycle T, alu_start T+1, alu_done earliest T+2, wb_valid earliest T+3.
REQ-029 No request accepted in WB on the handshake cycle; next accept no earlier than the following IDLE cycle.
REQ-030 err SHALL be sticky; only rst clears it; err does not block further requests.

Reset
REQ-031 rst=1 on a rising edge -> state IDLE, counter 0, err 0, latched operands 0, at any state including mid-WAIT or mid-WB.
REQ-032 Outputs during/after reset: req_ready=1, alu_start=0, wb_valid=0, wb_data=0, wb_reg=0, alu_a=alu_b=0, alu_sub=0.
REQ-033 An in-flight ALU operation interrupted by reset SHALL be discarded; a later alu_done in IDLE has no effect.

Structure
REQ-034 State encodings, op codes (SEQ/SLT/SGE/SCO) and default TIMEOUT SHALL live in a shared definitions file used by decode and set_ctrl.
REQ-035 Flag-to-bit selection SHALL be a combinational sub-module set_eval (op, zero, cout, msb -> bit); FSM, counter and registers in set_ctrl.

Verification
REQ-036 SEQ rs=0x1234, rt=0x1234, alu_done with zero=1 -> wb_data=0x0001, wb_reg=req_rd, alu_sub=1.
REQ-037 SLT rs=0x0003, rt=0x0005, msb=1; SGE same flags -> wb_data 0x0001 then 0x0000.
REQ-038 SCO rs=0xFFFF, rt=0x0001, cout=1 -> alu_sub=0, wb_data=0x0001; wb_ready held 0 for 3 cycles -> wb_valid and data stable throughout.
REQ-039 No alu_done for 15 WAIT cycles -> err=1, no wb_valid, req_ready=1 next cycle; second request completes normally, err stays 1; alu_done exactly on 15th cycle -> normal WB, err=0.
REQ-040 rst asserted mid-WAIT, then stray alu_done in IDLE -> no wb_valid, all outputs at reset values.
REQ-041 req_valid held high across back-to-back requests -> second accepted only after WB handshake plus return to IDLE; alu_start one cycle per request.

Source files
------------

// File: rtl/set_ctrl_pkg.sv
// Shared definitions for the set-instruction controller: op codes, FSM states
// and the default ALU timeout.
package set_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_SEQ = 2'b00,
        OP_SLT = 2'b01,
        OP_SGE = 2'b10,
        OP_SCO = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_WB
    } state_t;

    localparam int unsigned DEFAULT_TIMEOUT = 15;

endpackage

// File: rtl/set_ctrl_if.sv
// Request, ALU and write-back signal bundle for set_ctrl; the controller side
// uses the slave modport, the surrounding environment uses master.
interface set_ctrl_if;

    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [15:0] req_rs;
    logic [15:0] req_rt;
    logic [2:0]  req_rd;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic        alu_sub;
    logic        alu_start;
    logic        alu_done;
    logic        alu_zero;
    logic        alu_cout;
    logic        alu_msb;
    logic        wb_valid;
    logic        wb_ready;
    logic [15:0] wb_data;
    logic [2:0]  wb_reg;
    logic        err;

    modport slave (
        input  req_valid, req_op, req_rs, req_rt, req_rd,
        input  alu_done, alu_zero, alu_cout, alu_msb, wb_ready,
        output req_ready, alu_a, alu_b, alu_sub, alu_start,
        output wb_valid, wb_data, wb_reg, err
    );

    modport master (
        output req_valid, req_op, req_rs, req_rt, req_rd,
        output alu_done, alu_zero, alu_cout, alu_msb, wb_ready,
        input  req_ready, alu_a, alu_b, alu_sub, alu_start,
        input  wb_valid, wb_data, wb_reg, err
    );

endinterface

// File: rtl/set_ctrl_set_eval.sv
// Selects the set bit from the ALU flags according to the set-instruction op.
module set_eval
    import set_ctrl_pkg::*;
(
    input  op_t  op,
    input  logic zero,
    input  logic cout,
    input  logic msb,
    output logic set_bit
);

    always_comb begin
        set_bit = 1'b0;
        case (op)
            OP_SEQ:  set_bit = zero;
            OP_SLT:  set_bit = msb;
            OP_SGE:  set_bit = ~msb;
            OP_SCO:  set_bit = cout;
            default: set_bit = 1'b0;
        endcase
    end

endmodule

// File: rtl/set_ctrl.sv
// Set-instruction controller: accepts a request, launches one ALU operation,
// turns the returned flags into a 0/1 result and hands it to write-back.
module set_ctrl
    import set_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
)
(
    input logic      clk,
    input logic      rst,
    set_ctrl_if.slave bus
);

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_t      state;
    state_t      state_nx;
    op_t         op_q;
    logic [15:0] rs_q;
    logic [15:0] rt_q;
    logic [2:0]  rd_q;
    logic        set_q;
    logic        err_q;
    logic [15:0] cnt;
    logic        eval_bit;

    set_eval u_set_eval (
        .op      (op_q),
        .zero    (bus.alu_zero),
        .cout    (bus.alu_cout),
        .msb     (bus.alu_msb),
        .set_bit (eval_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            op_q  <= OP_SEQ;
            rs_q  <= '0;
            rt_q  <= '0;
            rd_q  <= '0;
            set_q <= 1'b0;
            err_q <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        op_q <= op_t'(bus.req_op);
                        rs_q <= bus.req_rs;
                        rt_q <= bus.req_rt;
                        rd_q <= bus.req_rd;
                    end
                end
                S_ISSUE: cnt <= '0;
                S_WAIT: begin
                    // a done on the last allowed cycle takes priority over the timeout
                    if (bus.alu_done)
                        set_q <= eval_bit;
                    else if (cnt == CNT_LAST)
                        err_q <= 1'b1;
                    else
                        cnt <= cnt + 16'd1;
                end
                default: ;
            endcase
        end
    end

    // Operand and result buses are gated to their active states so that idle
    // outputs read as zero regardless of what was last latched.
    always_comb begin
        state_nx      = state;
        bus.req_ready = 1'b0;
        bus.alu_start = 1'b0;
        bus.alu_a     = '0;
        bus.alu_b     = '0;
        bus.alu_sub   = 1'b0;
        bus.wb_valid  = 1'b0;
        bus.wb_data   = '0;
        bus.wb_reg    = '0;
        case (state)
            S_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) state_nx = S_ISSUE;
            end
            S_ISSUE: begin
                bus.alu_start = 1'b1;
                bus.alu_a     = rs_q;
                bus.alu_b     = rt_q;
                bus.alu_sub   = (op_q != OP_SCO);
                state_nx      = S_WAIT;
            end
            S_WAIT: begin
                bus.alu_a   = rs_q;
                bus.alu_b   = rt_q;
                bus.alu_sub = (op_q != OP_SCO);
                if (bus.alu_done)
                    state_nx = S_WB;
                else if (cnt == CNT_LAST)
                    state_nx = S_IDLE;
            end
            S_WB: begin
                bus.wb_valid = 1'b1;
                bus.wb_data  = {15'b0, set_q};
                bus.wb_reg   = rd_q;
                if (bus.wb_ready) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign bus.err = err_q;

endmodule

// File: tb/tb_set_ctrl.sv
// Scoreboard bench for set_ctrl: stimulus pushes expected write-backs, an
// independent monitor pops and compares them on each write-back handshake.
module tb_set_ctrl;
    import set_ctrl_pkg::*;

    localparam int unsigned TO = 15;

    logic clk;
    logic rst;
    set_ctrl_if bus ();

    set_ctrl #(.TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned total;
    int unsigned pass;
    int unsigned n_req;
    int unsigned n_start;
    bit          exp_err;
    logic [18:0] exp_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) pass++;
        else $display("FAIL %s: got %0h required %0h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference result straight from the instruction semantics.
    function automatic logic model_bit(input op_t op, input logic [15:0] rs, input logic [15:0] rt);
        logic [15:0] diff;
        logic [16:0] sum;
        diff = rs - rt;
        sum  = {1'b0, rs} + {1'b0, rt};
        case (op)
            OP_SEQ:  return rs == rt;
            OP_SLT:  return diff[15];
            OP_SGE:  return ~diff[15];
            default: return sum[16];
        endcase
    endfunction

    // Monitor: one-per-cycle alu_start count, write-back hold stability, scoreboard pop.
    initial begin
        bit          hold;
        logic [15:0] hd;
        logic [2:0]  hr;
        logic [18:0] e;
        hold = 1'b0;
        hd   = '0;
        hr   = '0;
        forever begin
            @(negedge clk);
            if (bus.alu_start === 1'b1) n_start++;
            if (hold) begin
                check("wb_hold_valid", 32'(bus.wb_valid), 32'd1);
                check("wb_hold_data", 32'(bus.wb_data), 32'(hd));
                check("wb_hold_reg", 32'(bus.wb_reg), 32'(hr));
            end
            hold = bus.wb_valid && !bus.wb_ready && !rst;
            hd   = bus.wb_data;
            hr   = bus.wb_reg;
            if (bus.wb_valid && bus.wb_ready && !rst) begin
                if (exp_q.size() == 0) begin
                    total++;
                    $display("FAIL wb_unexpected: got write-back data %0h reg %0d, required none", bus.wb_data, bus.wb_reg);
                end else begin
                    e = exp_q.pop_front();
                    check("wb_data", 32'(bus.wb_data), 32'(e[15:0]));
                    check("wb_reg", 32'(bus.wb_reg), 32'(e[18:16]));
                end
            end
        end
    end

    // d < TO: alu_done on WAIT cycle d+1; d >= TO: never answer (timeout).
    task automatic do_req(input op_t op, input logic [15:0] rs, input logic [15:0] rt,
                          input logic [2:0] rd, input int unsigned d,
                          input int unsigned stall, input bit hold);
        int unsigned n;
        logic [16:0] s;
        logic        z, c, m;
        bus.req_op    = op;
        bus.req_rs    = rs;
        bus.req_rt    = rt;
        bus.req_rd    = rd;
        bus.req_valid = 1'b1;
        n = 0;
        while (!bus.req_ready && n < 64) begin
            tick();
            n++;
        end
        check("req_ready_wait", 32'(bus.req_ready), 32'd1);
        tick();
        if (!hold) bus.req_valid = 1'b0;
        n_req++;
        check("alu_start", 32'(bus.alu_start), 32'd1);
        check("req_ready_busy", 32'(bus.req_ready), 32'd0);
        check("alu_a", 32'(bus.alu_a), 32'(rs));
        check("alu_b", 32'(bus.alu_b), 32'(rt));
        check("alu_sub", 32'(bus.alu_sub), 32'(op != OP_SCO));
        if (bus.alu_sub) s = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 17'd1;
        else             s = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        z = (s[15:0] == 16'd0);
        c = s[16];
        m = s[15];
        tick();
        check("alu_start_pulse", 32'(bus.alu_start), 32'd0);
        if (d < TO) begin
            repeat (d) begin
                bus.alu_zero = 1'($urandom);
                bus.alu_cout = 1'($urandom);
                bus.alu_msb  = 1'($urandom);
                tick();
            end
            exp_q.push_back({rd, 15'b0, model_bit(op, rs, rt)});
            bus.alu_zero = z;
            bus.alu_cout = c;
            bus.alu_msb  = m;
            bus.alu_done = 1'b1;
            tick();
            bus.alu_done = 1'b0;
            bus.alu_zero = 1'($urandom);
            bus.alu_cout = 1'($urandom);
            bus.alu_msb  = 1'($urandom);
            check("wb_valid_latency", 32'(bus.wb_valid), 32'd1);
            repeat (stall) begin
                tick();
                check("req_ready_wb", 32'(bus.req_ready), 32'd0);
            end
            bus.wb_ready = 1'b1;
            check("req_ready_handshake", 32'(bus.req_ready), 32'd0);
            tick();
            bus.wb_ready = 1'b0;
            check("wb_valid_after", 32'(bus.wb_valid), 32'd0);
            check("req_ready_after", 32'(bus.req_ready), 32'd1);
        end else begin
            repeat (TO) begin
                check("timeout_no_wb", 32'(bus.wb_valid), 32'd0);
                tick();
            end
            exp_err = 1'b1;
            check("timeout_wb_valid", 32'(bus.wb_valid), 32'd0);
            check("timeout_req_ready", 32'(bus.req_ready), 32'd1);
        end
        check("err", 32'(bus.err), 32'(exp_err));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
        check({tag, "_alu_start"}, 32'(bus.alu_start), 32'd0);
        check({tag, "_wb_valid"}, 32'(bus.wb_valid), 32'd0);
        check({tag, "_wb_data"}, 32'(bus.wb_data), 32'd0);
        check({tag, "_wb_reg"}, 32'(bus.wb_reg), 32'd0);
        check({tag, "_alu_a"}, 32'(bus.alu_a), 32'd0);
        check({tag, "_alu_b"}, 32'(bus.alu_b), 32'd0);
        check({tag, "_alu_sub"}, 32'(bus.alu_sub), 32'd0);
        check({tag, "_err"}, 32'(bus.err), 32'd0);
    endtask

    initial begin
        op_t         op;
        logic [15:0] rs, rt;
        int unsigned d;
        total = 0; pass = 0; n_req = 0; n_start = 0; exp_err = 1'b0;
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_op = '0; bus.req_rs = '0; bus.req_rt = '0; bus.req_rd = '0;
        bus.alu_done = 1'b0; bus.alu_zero = 1'b0; bus.alu_cout = 1'b0; bus.alu_msb = 1'b0;
        bus.wb_ready = 1'b0;
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();
        check_reset_outputs("post_reset");

        do_req(OP_SEQ, 16'h1234, 16'h1234, 3'd5, 0, 0, 1'b0);
        do_req(OP_SLT, 16'h0003, 16'h0005, 3'd2, 1, 1, 1'b0);
        do_req(OP_SGE, 16'h0003, 16'h0005, 3'd3, 2, 0, 1'b0);
        do_req(OP_SCO, 16'hFFFF, 16'h0001, 3'd7, 0, 3, 1'b0);
        do_req(OP_SEQ, 16'h00AA, 16'h00AB, 3'd1, TO - 1, 0, 1'b0);
        do_req(OP_SLT, 16'h0010, 16'h0001, 3'd4, TO, 0, 1'b0);
        do_req(OP_SCO, 16'h8000, 16'h8000, 3'd6, 0, 0, 1'b0);
        do_req(OP_SEQ, 16'h0042, 16'h0042, 3'd0, 0, 1, 1'b1);
        do_req(OP_SGE, 16'h7000, 16'h1000, 3'd3, 0, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            op = op_t'($urandom_range(0, 3));
            rs = 16'($urandom);
            rt = ($urandom_range(0, 3) == 0) ? rs : 16'($urandom);
            d  = ($urandom_range(0, 9) == 0) ? TO : $urandom_range(0, TO - 1);
            do_req(op, rs, rt, 3'($urandom), d, $urandom_range(0, 3), 1'b0);
        end

        // Reset while WAIT is in progress, then a stray alu_done in IDLE.
        bus.req_op = OP_SEQ; bus.req_rs = 16'h5555; bus.req_rt = 16'h5555; bus.req_rd = 3'd2;
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        n_req++;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_err = 1'b0;
        check_reset_outputs("midwait_reset");
        bus.alu_zero = 1'b1;
        bus.alu_done = 1'b1;
        tick();
        bus.alu_done = 1'b0;
        tick();
        check_reset_outputs("stray_done");

        tick();
        check("alu_start_count", n_start, n_req);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
